// File: rtl/imem_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit
// words, writes them into the imem window and reports a status byte when done.
module imem_loader #(
    parameter int         BASE_WORD = 0,
    parameter int         MAX_WORDS = 1024,
    parameter logic [7:0] ACK_OK    = 8'hAA,
    parameter logic [7:0] ACK_ERR   = 8'h55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [29:0] daddr,
    output logic [31:0] op2,
    output logic        dec_mwe,
    output logic        core_hold,
    output logic        done,
    input  logic        start
);

    localparam logic [1:0] ST_LEN  = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] MAX_W  = 32'(MAX_WORDS);
    localparam logic [31:0] BASE_W = 32'(BASE_WORD);
    localparam logic [29:0] DADDR_RESET = {5'b11111, 25'b0};

    logic [1:0]  state_reg;
    logic [1:0]  bcnt_reg;
    logic [23:0] asm_reg;
    logic [31:0] n_reg;
    logic [31:0] wcnt_reg;
    logic        err_reg;
    logic        dec_mwe_reg;
    logic [29:0] daddr_reg;
    logic [31:0] op2_reg;

    logic        byte_take;
    logic        word_last;
    logic [31:0] word_full;
    logic [11:0] idx;

    assign byte_take = rx_valid && ((state_reg == ST_LEN) || (state_reg == ST_DATA));
    assign word_last = byte_take && (bcnt_reg == 2'd3);
    // The 4th byte is combined directly so the write can be issued next cycle.
    assign word_full = {rx_data, asm_reg};
    assign idx       = 12'(BASE_W + wcnt_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_LEN;
            bcnt_reg    <= 2'd0;
            asm_reg     <= 24'd0;
            n_reg       <= 32'd0;
            wcnt_reg    <= 32'd0;
            err_reg     <= 1'b0;
            dec_mwe_reg <= 1'b0;
            daddr_reg   <= DADDR_RESET;
            op2_reg     <= 32'd0;
        end else begin
            dec_mwe_reg <= 1'b0;

            if (byte_take) begin
                bcnt_reg <= bcnt_reg + 2'd1;
                case (bcnt_reg)
                    2'd0:    asm_reg[7:0]   <= rx_data;
                    2'd1:    asm_reg[15:8]  <= rx_data;
                    2'd2:    asm_reg[23:16] <= rx_data;
                    default: ;
                endcase
            end

            if (word_last) begin
                if (state_reg == ST_LEN) begin
                    n_reg    <= word_full;
                    wcnt_reg <= 32'd0;
                    if (word_full == 32'd0) begin
                        state_reg <= ST_ACK;
                    end else begin
                        state_reg <= ST_DATA;
                        err_reg   <= (word_full > MAX_W);
                    end
                end else begin
                    // Words beyond the writable range are drained without a write.
                    if (wcnt_reg < MAX_W) begin
                        dec_mwe_reg <= 1'b1;
                        daddr_reg   <= {5'b11111, 13'b0, idx};
                        op2_reg     <= word_full;
                    end
                    wcnt_reg <= wcnt_reg + 32'd1;
                    if ((wcnt_reg + 32'd1) == n_reg) begin
                        state_reg <= ST_ACK;
                    end
                end
            end

            if ((state_reg == ST_ACK) && tx_ready) begin
                state_reg <= ST_DONE;
            end

            if ((state_reg == ST_DONE) && start) begin
                state_reg <= ST_LEN;
                bcnt_reg  <= 2'd0;
                err_reg   <= 1'b0;
                n_reg     <= 32'd0;
            end
        end
    end

    assign tx_valid  = (state_reg == ST_ACK);
    assign tx_data   = (state_reg == ST_ACK) ? (err_reg ? ACK_ERR : ACK_OK) : 8'd0;
    assign dec_mwe   = dec_mwe_reg;
    assign daddr     = daddr_reg;
    assign op2       = op2_reg;
    assign core_hold = (state_reg != ST_DONE);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a load-level model queues the
// expected writes and status bytes, a negedge monitor compares what appears.
module tb_imem_loader;

    localparam int BASE = 0;
    localparam int MAXW = 4;

    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [29:0] daddr;
    logic [31:0] op2;
    logic        dec_mwe;
    logic        core_hold;
    logic        done;
    logic        start;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [29:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  exp_ack_q[$];
    int          wr_cycles[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader #(
        .BASE_WORD(BASE),
        .MAX_WORDS(MAXW),
        .ACK_OK(8'hAA),
        .ACK_ERR(8'h55)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .daddr(daddr),
        .op2(op2),
        .dec_mwe(dec_mwe),
        .core_hold(core_hold),
        .done(done),
        .start(start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and every status handshake is one transaction.
    always @(negedge clk) begin : monitor
        logic [29:0] ea;
        logic [31:0] ed;
        logic [7:0]  ek;
        if (!rst && dec_mwe) begin
            wr_cycles.push_back(cyc);
            $display("write daddr=0x%08h op2=0x%08h cycle=%0d", daddr, op2, cyc);
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", {31'b0, dec_mwe}, 32'd0);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("write_daddr", {2'b0, daddr}, {2'b0, ea});
                check("write_op2", op2, ed);
            end
        end
        if (!rst && tx_valid && tx_ready) begin
            $display("ack tx_data=0x%02h cycle=%0d", tx_data, cyc);
            if (exp_ack_q.size() == 0) begin
                check("unexpected_ack", {31'b0, tx_valid}, 32'd0);
            end else begin
                ek = exp_ack_q.pop_front();
                check("ack_byte", {24'b0, tx_data}, {24'b0, ek});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic word_q_t rand_words(input int n);
        word_q_t q;
        for (int i = 0; i < n; i++) q.push_back($urandom);
        return q;
    endfunction

    // Reference model: which words land where, and which status byte follows.
    task automatic model_load(input logic [31:0] n, input word_q_t words);
        logic [11:0] wi;
        for (int i = 0; i < int'(n); i++) begin
            if (i < MAXW) begin
                wi = 12'((BASE + i) % 4096);
                exp_addr_q.push_back({5'b11111, 13'b0, wi});
                exp_data_q.push_back(words[i]);
            end
        end
        exp_ack_q.push_back((n > MAXW) ? 8'h55 : 8'hAA);
    endtask

    task automatic send_load(input logic [31:0] n, input word_q_t words, input int gapmax);
        logic [7:0] bytes[$];
        for (int k = 0; k < 4; k++) bytes.push_back(n[8*k +: 8]);
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) bytes.push_back(words[i][8*k +: 8]);
        end
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i != bytes.size() - 1) begin
                repeat ($urandom_range(gapmax, 0)) tick();
            end
        end
    endtask

    task automatic finish_load(input int ready_delay);
        for (int i = 0; i < 200 && !tx_valid; i++) tick();
        check("tx_valid_rise", {31'b0, tx_valid}, 32'd1);
        repeat (ready_delay) tick();
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) tick();
        tx_ready = 1'b0;
        check("done_set", {31'b0, done}, 32'd1);
        check("core_hold_released", {31'b0, core_hold}, 32'd0);
        check("tx_valid_cleared", {31'b0, tx_valid}, 32'd0);
        check("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
        check("acks_outstanding", 32'(exp_ack_q.size()), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rearm_core_hold", {31'b0, core_hold}, 32'd1);
        check("rearm_done", {31'b0, done}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dec_mwe"}, {31'b0, dec_mwe}, 32'd0);
        check({tag, "_daddr"}, {2'b0, daddr}, 32'h3E000000);
        check({tag, "_op2"}, op2, 32'd0);
        check({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'd0);
        check({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
        check({tag, "_core_hold"}, {31'b0, core_hold}, 32'd1);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        word_q_t w;
        logic [31:0] n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        tx_ready = 1'b0;
        start    = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_hold", {31'b0, core_hold}, 32'd1);
        check("start_ignored_done", {31'b0, done}, 32'd0);

        // Directed two-word load; last write coincides with tx_valid rising.
        w = {32'hDEADBEEF, 32'h00000013};
        model_load(32'd2, w);
        send_load(32'd2, w, 1);
        check("last_write_strobe", {31'b0, dec_mwe}, 32'd1);
        check("last_write_tx_valid", {31'b0, tx_valid}, 32'd1);
        finish_load(2);

        // Empty program: status appears the cycle after the count.
        w = {};
        model_load(32'd0, w);
        send_load(32'd0, w, 2);
        check("n0_tx_valid", {31'b0, tx_valid}, 32'd1);
        check("n0_no_write", {31'b0, dec_mwe}, 32'd0);
        finish_load(0);

        // One word past the writable range.
        w = rand_words(MAXW + 1);
        model_load(32'(MAXW + 1), w);
        send_load(32'(MAXW + 1), w, 2);
        finish_load(1);

        // Back-to-back bytes: writes exactly four cycles apart.
        wr_cycles.delete();
        w = rand_words(4);
        model_load(32'd4, w);
        send_load(32'd4, w, 0);
        finish_load(0);
        check("b2b_write_count", 32'(wr_cycles.size()), 32'd4);
        for (int i = 1; i < wr_cycles.size(); i++) begin
            check("b2b_spacing", 32'(wr_cycles[i] - wr_cycles[i-1]), 32'd4);
        end

        // Transmitter stall with bytes arriving during ACK.
        w = rand_words(2);
        model_load(32'd2, w);
        send_load(32'd2, w, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            tick();
            check("stall_tx_valid", {31'b0, tx_valid}, 32'd1);
            check("stall_tx_data", {24'b0, tx_data}, 32'hAA);
            check("stall_not_done", {31'b0, done}, 32'd0);
        end
        rx_valid = 1'b0;
        finish_load(0);

        // Abort mid-word with reset, then reload.
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        tick();
        check_reset_values("abort");
        rst = 1'b0;
        w = rand_words(1);
        model_load(32'd1, w);
        send_load(32'd1, w, 1);
        finish_load(0);
        w = rand_words(2);
        model_load(32'd2, w);
        send_load(32'd2, w, 0);
        finish_load(3);

        // Randomized loads.
        for (int r = 0; r < 8; r++) begin
            n = 32'($urandom_range(MAXW + 2, 0));
            w = rand_words(int'(n));
            model_load(n, w);
            send_load(n, w, 3);
            finish_load($urandom_range(5, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader: the writer on the instruction-memory store port. Consumes a byte stream from the UART receiver, assembles little-endian 32-bit words and drives the imem write port (`daddr`/`op2`/`dec_mwe`) so that each word lands in the imem window (`daddr[29:25]` all ones). After the last word it returns a status byte to the UART transmitter and releases the core from hold.

## Interface

Parameters:
- `BASE_WORD`, 0: imem word index of the first loaded word.
- `MAX_WORDS`, 1024: writable words; the top of imem (4077..4095) is reserved for the resident loader.
- `ACK_OK`, 8'hAA: status byte sent when the load is in range.
- `ACK_ERR`, 8'h55: status byte sent when the word count exceeds `MAX_WORDS`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_valid` in 1: one-cycle strobe; `rx_data` valid.
- `rx_data` in 8: received byte.
- `tx_valid` out 1: status byte offered to the transmitter.
- `tx_data` out 8: status byte.
- `tx_ready` in 1: transmitter accepts `tx_data` when high with `tx_valid`.
- `daddr` out 30: imem write address: `{5'b11111, 13'b0, idx[11:0]}`.
- `op2` out 32: write data.
- `dec_mwe` out 1: one-cycle write strobe.
- `core_hold` out 1: high while loading; the core is held in reset.
- `done` out 1: high in DONE.
- `start` in 1: one-cycle re-arm pulse, honoured only in DONE.

## Operation

- Framing: 4-byte word count N, little-endian, then N words of 4 bytes each, little-endian (first byte goes to `[7:0]`).
- Byte counter `bcnt` (2 bits) is shared by both phases. A byte is accepted on any cycle with `rx_valid` high in LEN or DATA. It shifts into the assembly register at lane `bcnt`, then `bcnt` increments and wraps.
- State LEN: on the 4th byte, latch N (32 bits) and clear word counter `wcnt` (32 bits).
  - N==0: go to ACK with `ACK_OK`.
  - Otherwise go to DATA. `err` = (N > `MAX_WORDS`).
- State DATA: on the 4th byte of a word:
  - If `wcnt` < `MAX_WORDS`, issue a write next cycle at idx = (`BASE_WORD` + `wcnt`)[11:0].
  - If `wcnt` ≥ `MAX_WORDS`, the word is consumed with no write.
  - `wcnt` increments in both cases.
  - When `wcnt`+1 == N, go to ACK.
- State ACK: `tx_valid`=1, `tx_data` = `err` ? `ACK_ERR` : `ACK_OK`. Stays in ACK until `tx_valid && tx_ready`, then goes to DONE. `rx_valid` is ignored.
- State DONE: `core_hold`=0, `done`=1, `rx_valid` ignored. `start` goes to LEN and clears `bcnt`, `err` and N; `core_hold` returns to 1.
- All arithmetic is unsigned. `wcnt` cannot overflow in practice (N ≤ 2^32−1). The address wraps modulo 4096.

## Timing

- Reset values:
  - state=LEN.
  - `bcnt`=0, N=0, `wcnt`=0, `err`=0.
  - `dec_mwe`=0, `daddr`={5'b11111,25'b0}, `op2`=0.
  - `tx_valid`=0, `tx_data`=0.
  - `core_hold`=1, `done`=0.
- Write latency: `dec_mwe`, `daddr` and `op2` are registered. They are valid for exactly 1 cycle, starting the cycle after the 4th byte's `rx_valid`. `daddr` and `op2` hold their value afterwards; only `dec_mwe` deasserts.
- Back-to-back `rx_valid` on every cycle is supported with no byte loss. A byte accepted in the same cycle `dec_mwe` is high is processed normally.
- The last word's write is issued in the same cycle as entry to ACK. `tx_valid` rises that cycle.
- `tx_valid` and `tx_data` stay stable until the handshake completes. The transition to DONE happens on the cycle after the handshake.
- `rst` mid-load aborts immediately. A partial word is discarded, no write is issued, and the next byte is treated as count byte 0.
- `start` outside DONE is ignored.

## Test plan

- N=2, words 0xDEADBEEF and 0x00000013 (bytes 02 00 00 00 EF BE AD DE 13 00 00 00) -> exactly 2 `dec_mwe` pulses:
  - `daddr`=0x3E000000 with `op2`=0xDEADBEEF;
  - `daddr`=0x3E000001 with `op2`=0x00000013.
  - Then `tx_data`=0xAA, DONE, `core_hold`=0.
- N=0 -> no writes; ACK 0xAA on the cycle after the 4th count byte.
- `MAX_WORDS`=2, N=3 -> writes only at idx 0 and 1; the third word is consumed without a write; `tx_data`=0x55.
- `rx_valid` held high every cycle with N=4 -> 4 writes at consecutive indices, each 4 cycles apart, with no byte dropped.
- `tx_ready` held low for 10 cycles in ACK -> `tx_valid`=1 with stable `tx_data`; DONE only after `tx_ready` rises; `rx_valid` during the stall causes no write.
- `rst` after 2 bytes of word 1 -> all outputs return to their reset values with no write; a fresh N=1 load then writes idx 0 correctly. `start` in DONE -> `core_hold`=1 and a second load at idx 0.
